// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_pkg
// Description : Shared widths, ALU opselect encodings and the ID/EX stage
//               occupancy state type.
// Revision    : 1.0 - initial release
// ============================================================================
package id_ex_stage_pkg;

    localparam int c_data_w     = 32;
    localparam int c_reg_addr_w = 5;
    localparam int c_op_w       = 4;

    // ALU opselect encodings seen on alu.opselect
    localparam logic [c_op_w-1:0] c_op_and = 4'b0000;
    localparam logic [c_op_w-1:0] c_op_or  = 4'b0001;
    localparam logic [c_op_w-1:0] c_op_add = 4'b0010;
    localparam logic [c_op_w-1:0] c_op_sub = 4'b0110;
    localparam logic [c_op_w-1:0] c_op_slt = 4'b0111;
    localparam logic [c_op_w-1:0] c_op_nor = 4'b1100;

    // Stage occupancy: nothing held, main register held, main + skid held
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } stage_state_t;

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_if
// Description : Bundle of decode-side inputs, forwarding sources and ALU-side
//               outputs for the ID/EX stage. master = environment, slave = stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_stage_if
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W     = c_data_w,
    parameter int REG_ADDR_W = c_reg_addr_w,
    parameter int OP_W       = c_op_w
) ();

    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [OP_W-1:0]       in_opselect;
    logic [REG_ADDR_W-1:0] in_rs_addr;
    logic [REG_ADDR_W-1:0] in_rt_addr;
    logic [DATA_W-1:0]     in_rs_data;
    logic [DATA_W-1:0]     in_rt_data;
    logic [DATA_W-1:0]     in_imm;
    logic                  in_use_imm;
    logic [REG_ADDR_W-1:0] in_rd_addr;
    logic                  in_reg_write;
    logic                  exm_we;
    logic [REG_ADDR_W-1:0] exm_addr;
    logic [DATA_W-1:0]     exm_data;
    logic                  mwb_we;
    logic [REG_ADDR_W-1:0] mwb_addr;
    logic [DATA_W-1:0]     mwb_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [OP_W-1:0]       opselect;
    logic [DATA_W-1:0]     x;
    logic [DATA_W-1:0]     y;
    logic [REG_ADDR_W-1:0] out_rd_addr;
    logic                  out_reg_write;

    modport master (
        output flush, in_valid, in_opselect, in_rs_addr, in_rt_addr,
               in_rs_data, in_rt_data, in_imm, in_use_imm, in_rd_addr,
               in_reg_write, exm_we, exm_addr, exm_data, mwb_we, mwb_addr,
               mwb_data, out_ready,
        input  in_ready, out_valid, opselect, x, y, out_rd_addr, out_reg_write
    );

    modport slave (
        input  flush, in_valid, in_opselect, in_rs_addr, in_rt_addr,
               in_rs_data, in_rt_data, in_imm, in_use_imm, in_rd_addr,
               in_reg_write, exm_we, exm_addr, exm_data, mwb_we, mwb_addr,
               mwb_data, out_ready,
        output in_ready, out_valid, opselect, x, y, out_rd_addr, out_reg_write
    );

endinterface
`default_nettype wire

// File: rtl/id_ex_stage_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : operand_fwd_mux
// Description : Selects one source operand from EX/MEM, MEM/WB or the register
//               file. EX/MEM is younger and wins; register 0 is never forwarded.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W     = c_data_w,
    parameter int REG_ADDR_W = c_reg_addr_w
) (
    input  wire logic [REG_ADDR_W-1:0] i_src_addr,
    input  wire logic [DATA_W-1:0]     i_rf_data,
    input  wire logic                  i_exm_we,
    input  wire logic [REG_ADDR_W-1:0] i_exm_addr,
    input  wire logic [DATA_W-1:0]     i_exm_data,
    input  wire logic                  i_mwb_we,
    input  wire logic [REG_ADDR_W-1:0] i_mwb_addr,
    input  wire logic [DATA_W-1:0]     i_mwb_data,
    output logic      [DATA_W-1:0]     o_data
);

    // Priority select: EX/MEM hit, then MEM/WB hit, else register-file value
    always_comb begin
        o_data = i_rf_data;
        if (i_src_addr != '0) begin
            if (i_exm_we && (i_exm_addr == i_src_addr)) begin
                o_data = i_exm_data;
            end else if (i_mwb_we && (i_mwb_addr == i_src_addr)) begin
                o_data = i_mwb_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : Decode-to-execute pipeline stage. Resolves operand forwarding
//               at accept time and presents registered opselect/x/y to the ALU
//               through a 2-entry skid buffer so in_ready is registered.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W     = c_data_w,
    parameter int REG_ADDR_W = c_reg_addr_w,
    parameter int OP_W       = c_op_w
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    id_ex_stage_if.slave  bus
);

    logic [DATA_W-1:0]     w_fwd_rs;
    logic [DATA_W-1:0]     w_fwd_rt;
    logic [DATA_W-1:0]     w_new_y;
    logic                  w_accept;
    logic                  w_release;

    stage_state_t          r_state;
    logic                  r_out_valid;
    logic                  r_in_ready;

    // Main register: what the ALU currently sees
    logic [OP_W-1:0]       r_m_op;
    logic [DATA_W-1:0]     r_m_x;
    logic [DATA_W-1:0]     r_m_y;
    logic [REG_ADDR_W-1:0] r_m_rd;
    logic                  r_m_rw;

    // Skid register: second instruction taken while the ALU side stalled
    logic [OP_W-1:0]       r_s_op;
    logic [DATA_W-1:0]     r_s_x;
    logic [DATA_W-1:0]     r_s_y;
    logic [REG_ADDR_W-1:0] r_s_rd;
    logic                  r_s_rw;

    operand_fwd_mux #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_rs (
        .i_src_addr (bus.in_rs_addr),
        .i_rf_data  (bus.in_rs_data),
        .i_exm_we   (bus.exm_we),
        .i_exm_addr (bus.exm_addr),
        .i_exm_data (bus.exm_data),
        .i_mwb_we   (bus.mwb_we),
        .i_mwb_addr (bus.mwb_addr),
        .i_mwb_data (bus.mwb_data),
        .o_data     (w_fwd_rs)
    );

    operand_fwd_mux #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_rt (
        .i_src_addr (bus.in_rt_addr),
        .i_rf_data  (bus.in_rt_data),
        .i_exm_we   (bus.exm_we),
        .i_exm_addr (bus.exm_addr),
        .i_exm_data (bus.exm_data),
        .i_mwb_we   (bus.mwb_we),
        .i_mwb_addr (bus.mwb_addr),
        .i_mwb_data (bus.mwb_data),
        .o_data     (w_fwd_rt)
    );

    assign w_new_y   = bus.in_use_imm ? bus.in_imm : w_fwd_rt;
    assign w_accept  = bus.in_valid & r_in_ready;
    assign w_release = r_out_valid & bus.out_ready;

    // Occupancy FSM with registered handshakes; operands are captured already
    // forwarded, so held entries never look at the forwarding buses again
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_m_op      <= '0;
            r_m_x       <= '0;
            r_m_y       <= '0;
            r_m_rd      <= '0;
            r_m_rw      <= 1'b0;
            r_s_op      <= '0;
            r_s_x       <= '0;
            r_s_y       <= '0;
            r_s_rd      <= '0;
            r_s_rw      <= 1'b0;
        end else if (bus.flush) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            unique case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_m_op      <= bus.in_opselect;
                        r_m_x       <= w_fwd_rs;
                        r_m_y       <= w_new_y;
                        r_m_rd      <= bus.in_rd_addr;
                        r_m_rw      <= bus.in_reg_write;
                        r_out_valid <= 1'b1;
                        r_state     <= FULL;
                    end
                end
                FULL: begin
                    if (w_accept && w_release) begin
                        r_m_op      <= bus.in_opselect;
                        r_m_x       <= w_fwd_rs;
                        r_m_y       <= w_new_y;
                        r_m_rd      <= bus.in_rd_addr;
                        r_m_rw      <= bus.in_reg_write;
                    end else if (w_accept) begin
                        r_s_op      <= bus.in_opselect;
                        r_s_x       <= w_fwd_rs;
                        r_s_y       <= w_new_y;
                        r_s_rd      <= bus.in_rd_addr;
                        r_s_rw      <= bus.in_reg_write;
                        r_in_ready  <= 1'b0;
                        r_state     <= SKID;
                    end else if (w_release) begin
                        r_out_valid <= 1'b0;
                        r_state     <= EMPTY;
                    end
                end
                SKID: begin
                    if (w_release) begin
                        r_m_op      <= r_s_op;
                        r_m_x       <= r_s_x;
                        r_m_y       <= r_s_y;
                        r_m_rd      <= r_s_rd;
                        r_m_rw      <= r_s_rw;
                        r_in_ready  <= 1'b1;
                        r_state     <= FULL;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready      = r_in_ready;
    assign bus.out_valid     = r_out_valid;
    assign bus.opselect      = r_m_op;
    assign bus.x             = r_m_x;
    assign bus.y             = r_m_y;
    assign bus.out_rd_addr   = r_m_rd;
    assign bus.out_reg_write = r_m_rw;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Self-checking bench for id_ex_stage: reset, a vector table of
//               forwarding/immediate cases, backpressure and flush sequences,
//               and random traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [c_op_w-1:0]       op;
        logic [c_reg_addr_w-1:0] rs_a;
        logic [c_reg_addr_w-1:0] rt_a;
        logic [c_data_w-1:0]     rs_d;
        logic [c_data_w-1:0]     rt_d;
        logic [c_data_w-1:0]     imm;
        logic                    use_imm;
        logic                    exm_we;
        logic [c_reg_addr_w-1:0] exm_a;
        logic [c_data_w-1:0]     exm_d;
        logic                    mwb_we;
        logic [c_reg_addr_w-1:0] mwb_a;
        logic [c_data_w-1:0]     mwb_d;
        logic [c_data_w-1:0]     exp_x;
        logic [c_data_w-1:0]     exp_y;
    } vec_t;

    typedef struct packed {
        logic [c_op_w-1:0]       op;
        logic [c_data_w-1:0]     x;
        logic [c_data_w-1:0]     y;
        logic [c_reg_addr_w-1:0] rd;
        logic                    rw;
    } ent_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.flush        = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_opselect  = '0;
        bus.in_rs_addr   = '0;
        bus.in_rt_addr   = '0;
        bus.in_rs_data   = '0;
        bus.in_rt_data   = '0;
        bus.in_imm       = '0;
        bus.in_use_imm   = 1'b0;
        bus.in_rd_addr   = '0;
        bus.in_reg_write = 1'b0;
        bus.exm_we       = 1'b0;
        bus.exm_addr     = '0;
        bus.exm_data     = '0;
        bus.mwb_we       = 1'b0;
        bus.mwb_addr     = '0;
        bus.mwb_data     = '0;
        bus.out_ready    = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Simple instruction with no forwarding hits: x = rs_data, y = rt_data
    task automatic push_plain(input logic [31:0] xv, input logic [31:0] yv);
        bus.in_valid    = 1'b1;
        bus.in_opselect = c_op_add;
        bus.in_rs_addr  = 5'd1;
        bus.in_rt_addr  = 5'd2;
        bus.in_rs_data  = xv;
        bus.in_rt_data  = yv;
        bus.in_use_imm  = 1'b0;
        bus.exm_we      = 1'b0;
        bus.mwb_we      = 1'b0;
    endtask

    // Reference forwarding rule on the values currently driven by the bench
    function automatic logic [c_data_w-1:0] ref_fwd(input logic [c_reg_addr_w-1:0] a,
                                                    input logic [c_data_w-1:0] rf);
        if (a != 0 && bus.exm_we && bus.exm_addr == a) return bus.exm_data;
        if (a != 0 && bus.mwb_we && bus.mwb_addr == a) return bus.mwb_data;
        return rf;
    endfunction

    vec_t vecs[7];
    ent_t q[$];

    initial begin
        // ---------------- reset held with in_valid asserted ----------------
        idle_inputs();
        rst_n = 1'b0;
        push_plain(32'h1234_5678, 32'h9ABC_DEF0);
        bus.in_rd_addr   = 5'd9;
        bus.in_reg_write = 1'b1;
        bus.out_ready    = 1'b1;
        repeat (3) tick();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_x", bus.x, 0);
        chk("rst_y", bus.y, 0);
        chk("rst_op", bus.opselect, 0);
        chk("rst_rd", {bus.out_rd_addr, bus.out_reg_write}, 0);
        idle_inputs();
        rst_n = 1'b1;
        tick();
        chk("post_rst_out_valid", bus.out_valid, 0);
        chk("post_rst_in_ready", bus.in_ready, 1);

        // ---------------- vector table: forwarding and immediate ----------------
        vecs[0] = '{4'h2, 5'd1,  5'd2,  32'd5,  32'd7,  32'd0,        1'b0,
                    1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,
                    32'd5, 32'd7};
        vecs[1] = '{4'h2, 5'd3,  5'd4,  32'd1,  32'd2,  32'd0,        1'b0,
                    1'b1, 5'd3,  32'hAAAA_AAAA, 1'b1, 5'd3,  32'h5555_5555,
                    32'hAAAA_AAAA, 32'd2};
        vecs[2] = '{4'h0, 5'd0,  5'd0,  32'h10, 32'h20, 32'd0,        1'b0,
                    1'b1, 5'd0,  32'hDEAD,     1'b1, 5'd0,  32'hBEEF,
                    32'h10, 32'h20};
        vecs[3] = '{4'h6, 5'd1,  5'd6,  32'd3,  32'd9,  32'hFFFF_FFFC, 1'b1,
                    1'b1, 5'd6,  32'h1234,     1'b0, 5'd0,  32'd0,
                    32'd3, 32'hFFFF_FFFC};
        vecs[4] = '{4'h1, 5'd7,  5'd8,  32'h70, 32'h80, 32'd0,        1'b0,
                    1'b1, 5'd9,  32'h99,       1'b1, 5'd8,  32'h88,
                    32'h70, 32'h88};
        vecs[5] = '{4'h7, 5'd5,  5'd5,  32'h50, 32'h51, 32'd0,        1'b0,
                    1'b0, 5'd5,  32'hE0,       1'b1, 5'd5,  32'hF0,
                    32'hF0, 32'hF0};
        vecs[6] = '{4'hC, 5'd10, 5'd11, 32'hA0, 32'hB0, 32'd0,        1'b0,
                    1'b1, 5'd11, 32'hB1,       1'b1, 5'd10, 32'hA1,
                    32'hA1, 32'hB1};

        bus.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.in_valid     = 1'b1;
            bus.in_opselect  = vecs[i].op;
            bus.in_rs_addr   = vecs[i].rs_a;
            bus.in_rt_addr   = vecs[i].rt_a;
            bus.in_rs_data   = vecs[i].rs_d;
            bus.in_rt_data   = vecs[i].rt_d;
            bus.in_imm       = vecs[i].imm;
            bus.in_use_imm   = vecs[i].use_imm;
            bus.in_rd_addr   = 5'(i + 1);
            bus.in_reg_write = i[0];
            bus.exm_we       = vecs[i].exm_we;
            bus.exm_addr     = vecs[i].exm_a;
            bus.exm_data     = vecs[i].exm_d;
            bus.mwb_we       = vecs[i].mwb_we;
            bus.mwb_addr     = vecs[i].mwb_a;
            bus.mwb_data     = vecs[i].mwb_d;
            tick();
            bus.in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), bus.out_valid, 1);
            chk($sformatf("vec%0d_op", i), bus.opselect, vecs[i].op);
            chk($sformatf("vec%0d_x", i), bus.x, vecs[i].exp_x);
            chk($sformatf("vec%0d_y", i), bus.y, vecs[i].exp_y);
            chk($sformatf("vec%0d_rd", i), {bus.out_rd_addr, bus.out_reg_write},
                {5'(i + 1), i[0]});
        end
        tick();
        chk("vec_drain_valid", bus.out_valid, 0);

        // ---------------- backpressure: A, B held, C waits upstream ----------------
        do_reset();
        bus.out_ready = 1'b0;
        push_plain(32'hA, 32'hA0);
        tick();
        chk("bp_a_valid", bus.out_valid, 1);
        chk("bp_a_x", bus.x, 32'hA);
        chk("bp_a_ready", bus.in_ready, 1);
        push_plain(32'hB, 32'hB0);
        tick();
        chk("bp_skid_ready", bus.in_ready, 0);
        chk("bp_skid_x", bus.x, 32'hA);
        push_plain(32'hC, 32'hC0);
        // Change forwarding buses while stalled; held operands must not move
        bus.exm_we   = 1'b1;
        bus.exm_addr = 5'd1;
        bus.exm_data = 32'hFFFF_0000;
        tick();
        chk("bp_hold_x", bus.x, 32'hA);
        chk("bp_hold_ready", bus.in_ready, 0);
        bus.exm_we    = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("bp_out_b", {bus.out_valid, bus.x, bus.y}, {1'b1, 32'hB, 32'hB0});
        chk("bp_ready_back", bus.in_ready, 1);
        tick();
        chk("bp_out_c", {bus.out_valid, bus.x, bus.y}, {1'b1, 32'hC, 32'hC0});
        bus.in_valid = 1'b0;
        tick();
        chk("bp_drained", bus.out_valid, 0);

        // ---------------- flush while in SKID ----------------
        do_reset();
        bus.out_ready = 1'b0;
        push_plain(32'h1, 32'h2);
        tick();
        push_plain(32'h3, 32'h4);
        tick();
        chk("fl_pre_ready", bus.in_ready, 0);
        push_plain(32'hD, 32'hD0);
        bus.flush = 1'b1;
        tick();
        chk("fl_valid", bus.out_valid, 0);
        chk("fl_ready", bus.in_ready, 1);
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("fl_never_%0d", i), bus.out_valid, 0);
        end

        // ---------------- random traffic vs queue model ----------------
        do_reset();
        q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            ent_t ne;
            bit   acc;
            bit   rel;
            rst_n            = ($urandom_range(0, 99) != 0);
            bus.flush        = ($urandom_range(0, 15) == 0);
            bus.in_valid     = ($urandom_range(0, 3) != 0);
            bus.out_ready    = ($urandom_range(0, 2) != 0);
            bus.in_opselect  = 4'($urandom);
            bus.in_rs_addr   = 5'($urandom_range(0, 3));
            bus.in_rt_addr   = 5'($urandom_range(0, 3));
            bus.in_rs_data   = $urandom;
            bus.in_rt_data   = $urandom;
            bus.in_imm       = $urandom;
            bus.in_use_imm   = 1'($urandom);
            bus.in_rd_addr   = 5'($urandom);
            bus.in_reg_write = 1'($urandom);
            bus.exm_we       = 1'($urandom);
            bus.exm_addr     = 5'($urandom_range(0, 3));
            bus.exm_data     = $urandom;
            bus.mwb_we       = 1'($urandom);
            bus.mwb_addr     = 5'($urandom_range(0, 3));
            bus.mwb_data     = $urandom;

            ne.op = bus.in_opselect;
            ne.x  = ref_fwd(bus.in_rs_addr, bus.in_rs_data);
            ne.y  = bus.in_use_imm ? bus.in_imm : ref_fwd(bus.in_rt_addr, bus.in_rt_data);
            ne.rd = bus.in_rd_addr;
            ne.rw = bus.in_reg_write;
            acc   = bus.in_valid && (q.size() < 2);
            rel   = (q.size() > 0) && bus.out_ready;

            tick();

            if (!rst_n || bus.flush) begin
                q.delete();
            end else begin
                if (rel) void'(q.pop_front());
                if (acc) q.push_back(ne);
            end

            chk($sformatf("rnd%0d_valid", cyc), bus.out_valid, (q.size() > 0));
            chk($sformatf("rnd%0d_ready", cyc), bus.in_ready, (q.size() < 2));
            if (q.size() > 0) begin
                chk($sformatf("rnd%0d_data", cyc),
                    {bus.opselect, bus.x, bus.y, bus.out_rd_addr, bus.out_reg_write}, q[0]);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
